// File: rtl/pulse_sequencer_v2_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : pulse_sequencer_v2_if
//  Description : Control and timing bundle between a burst controller and the
//                pulse_sequencer_v2 timing generator.
//                master : drives the burst request and pulse parameters,
//                         observes gate/strobe/status outputs.
//                slave  : the sequencer itself.
//  Signals     : SIGN_START_GEN, SIGNAL_TYPE, T_IMPULSE, T_PERIOD,
//                NUM_OF_IMP, STAGGER  (master -> slave)
//                GATE, IMP_START, IMP_INDEX, TYPE_OUT, BUSY, DONE, ERR
//                                     (slave -> master)
//  Revision    : 2.0 - initial interface for the v2 sequencer
// ============================================================================
interface pulse_sequencer_v2_if #(
    parameter int T_IMP_W = 10,
    parameter int T_PER_W = 13,
    parameter int NUM_W   = 5,
    parameter int STAG_W  = 8
);
    // Request side
    logic               SIGN_START_GEN;
    logic [1:0]         SIGNAL_TYPE;
    logic [T_IMP_W-1:0] T_IMPULSE;
    logic [T_PER_W-1:0] T_PERIOD;
    logic [NUM_W-1:0]   NUM_OF_IMP;
    logic [STAG_W-1:0]  STAGGER;

    // Timing / status side
    logic               GATE;
    logic               IMP_START;
    logic [NUM_W-1:0]   IMP_INDEX;
    logic [1:0]         TYPE_OUT;
    logic               BUSY;
    logic               DONE;
    logic               ERR;

    modport master (
        output SIGN_START_GEN, SIGNAL_TYPE, T_IMPULSE, T_PERIOD,
               NUM_OF_IMP, STAGGER,
        input  GATE, IMP_START, IMP_INDEX, TYPE_OUT, BUSY, DONE, ERR
    );

    modport slave (
        input  SIGN_START_GEN, SIGNAL_TYPE, T_IMPULSE, T_PERIOD,
               NUM_OF_IMP, STAGGER,
        output GATE, IMP_START, IMP_INDEX, TYPE_OUT, BUSY, DONE, ERR
    );
endinterface
`default_nettype wire

// File: rtl/pulse_sequencer_v2.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : pulse_sequencer_v2
//  Description : Burst timing generator. Converts pulse width / period (in us)
//                and pulse count into a clock-exact GATE, a per-pulse
//                IMP_START strobe and a pulse index for the waveform cores.
//                NUM_OF_IMP == 0 selects continuous mode, where the level of
//                SIGN_START_GEN acts as the run enable and the burst stops at
//                the end of the period in which the level was seen low.
//  Ports       : CLK    - single rising-edge clock
//                RESET  - synchronous, active-high
//                bus    - pulse_sequencer_v2_if.slave (request parameters in,
//                         GATE/IMP_START/IMP_INDEX/TYPE_OUT/BUSY/DONE/ERR out)
//  Options     : PULSE_SEQ_STAGGER_EN - when defined, odd-indexed pulses use a
//                period of T_PERIOD + STAGGER; otherwise STAGGER is ignored.
//  Revision    : 2.0 - generic widths, continuous mode, validation,
//                      busy/done handshake, optional stagger
// ============================================================================
module pulse_sequencer_v2 #(
    parameter int CLK_PER_US = 500,
    parameter int T_IMP_W    = 10,
    parameter int T_PER_W    = 13,
    parameter int NUM_W      = 5,
    parameter int STAG_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    pulse_sequencer_v2_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int c_US_W  = T_PER_W + 1;
    // Comparison width wide enough for both pulse-width and period values
    // so validation and end-of-phase compares never truncate.
    localparam int c_CMP_W = ((T_IMP_W > T_PER_W) ? T_IMP_W : T_PER_W) + 1;

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(CLK_PER_US - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
    localparam logic [c_US_W-1:0]  c_US_ONE   = c_US_W'(1);
    localparam logic [c_CMP_W-1:0] c_CMP_ONE  = c_CMP_W'(1);
    localparam logic [NUM_W-1:0]   c_IDX_ONE  = NUM_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ON   = 2'd1;
    localparam logic [1:0] c_OFF  = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic               r_start_prev;
    logic [c_PRE_W-1:0] r_presc;
    logic [c_US_W-1:0]  r_us_cnt;
    logic [NUM_W-1:0]   r_index;
    logic [1:0]         r_type;
    logic [T_IMP_W-1:0] r_t_imp;
    logic [T_PER_W-1:0] r_t_per;
    logic [NUM_W-1:0]   r_num;
    logic               r_stop;
    logic               r_imp_start;
    logic               r_done;
    logic               r_err;

    logic               w_start_edge;
    logic               w_params_ok;
    logic               w_accept;
    logic               w_tick;
    logic [c_US_W-1:0]  w_period;
    logic [c_CMP_W-1:0] w_imp_last;
    logic [c_CMP_W-1:0] w_per_last;
    logic               w_imp_end;
    logic               w_per_end;
    logic [NUM_W-1:0]   w_idx_next;
    logic               w_burst_end;

    // ------------------------------------------------------------------------
    // Start detection and parameter validation (uses live inputs: they are
    // latched on the same edge the start is accepted).
    // ------------------------------------------------------------------------
    assign w_start_edge = bus.SIGN_START_GEN & ~r_start_prev;

    assign w_params_ok  = (bus.T_IMPULSE != '0) &&
                          (c_CMP_W'(bus.T_PERIOD) > c_CMP_W'(bus.T_IMPULSE));

    assign w_accept     = (r_state == c_IDLE) && w_start_edge && w_params_ok;

    // ------------------------------------------------------------------------
    // Microsecond timebase: tick on the last prescaler count.
    // ------------------------------------------------------------------------
    assign w_tick = (r_presc == c_PRE_LAST);

    // ------------------------------------------------------------------------
    // Period selection. The stagger term only exists when enabled; the sum is
    // formed one bit wider than T_PERIOD so it cannot wrap.
    // ------------------------------------------------------------------------
`ifdef PULSE_SEQ_STAGGER_EN
    logic [STAG_W-1:0] r_stag;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stag <= '0;
        end else if (w_accept) begin
            r_stag <= bus.STAGGER;
        end
    end

    assign w_period = r_index[0] ? (c_US_W'(r_t_per) + c_US_W'(r_stag))
                                 : c_US_W'(r_t_per);
`else
    assign w_period = c_US_W'(r_t_per);
`endif

    // Last microsecond of each phase. Validation guarantees T_IMPULSE >= 1
    // and period >= 2, so neither subtraction underflows.
    assign w_imp_last  = c_CMP_W'(r_t_imp) - c_CMP_ONE;
    assign w_per_last  = c_CMP_W'(w_period) - c_CMP_ONE;
    assign w_imp_end   = (c_CMP_W'(r_us_cnt) == w_imp_last);
    assign w_per_end   = (c_CMP_W'(r_us_cnt) == w_per_last);

    // Index after the current period; wraps naturally in continuous mode.
    assign w_idx_next  = r_index + c_IDX_ONE;

    // Finite bursts end on pulse count; continuous bursts end only once the
    // run-enable has been seen low at some point during the burst.
    assign w_burst_end = (r_num == '0) ? r_stop : (w_idx_next == r_num);

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= c_IDLE;
            r_start_prev <= 1'b0;
            r_presc      <= '0;
            r_us_cnt     <= '0;
            r_index      <= '0;
            r_type       <= '0;
            r_t_imp      <= '0;
            r_t_per      <= '0;
            r_num        <= '0;
            r_stop       <= 1'b0;
            r_imp_start  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_start_prev <= bus.SIGN_START_GEN;
            r_imp_start  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    // Outputs hold their last values while idle.
                    if (w_start_edge) begin
                        if (w_params_ok) begin
                            r_state     <= c_ON;
                            r_t_imp     <= bus.T_IMPULSE;
                            r_t_per     <= bus.T_PERIOD;
                            r_num       <= bus.NUM_OF_IMP;
                            r_type      <= bus.SIGNAL_TYPE;
                            r_index     <= '0;
                            r_stop      <= 1'b0;
                            r_presc     <= '0;
                            r_us_cnt    <= '0;
                            r_imp_start <= 1'b1;
                        end else begin
                            r_err       <= 1'b1;
                        end
                    end
                end

                c_ON, c_OFF: begin
                    // Start edges are ignored while busy; only the level is
                    // observed, and only continuous mode acts on it.
                    if (!bus.SIGN_START_GEN) begin
                        r_stop <= 1'b1;
                    end

                    r_presc <= w_tick ? '0 : (r_presc + c_PRE_ONE);

                    if (w_tick) begin
                        if (r_state == c_ON) begin
                            // us_cnt keeps running through OFF so the period
                            // is measured from the start of the pulse.
                            r_us_cnt <= r_us_cnt + c_US_ONE;
                            if (w_imp_end) begin
                                r_state <= c_OFF;
                            end
                        end else if (w_per_end) begin
                            r_us_cnt <= '0;
                            if (w_burst_end) begin
                                r_state <= c_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= c_ON;
                                r_index     <= w_idx_next;
                                r_imp_start <= 1'b1;
                            end
                        end else begin
                            r_us_cnt <= r_us_cnt + c_US_ONE;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.GATE      = (r_state == c_ON);
    assign bus.BUSY      = (r_state != c_IDLE);
    assign bus.IMP_START = r_imp_start;
    assign bus.IMP_INDEX = r_index;
    assign bus.TYPE_OUT  = r_type;
    assign bus.DONE      = r_done;
    assign bus.ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer_v2.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_sequencer_v2
//  Description : Scoreboard bench for pulse_sequencer_v2 at CLK_PER_US = 4.
//                Stimulus pushes the expected strobe events (kind, cycle,
//                index, type); a negedge monitor pops and compares each
//                IMP_START / DONE / ERR the DUT presents.
//  Revision    : 2.0 - initial bench
// ============================================================================
module tb_pulse_sequencer_v2;

    localparam int CPU = 4;

    localparam logic [1:0] K_IMP  = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [4:0]  idx;
        logic [1:0]  typ;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int   n_checks = 0;
    int   n_fail   = 0;

    ev_t  exp_q[$];
    int   n_imp      = 0;
    int   gate_cnt   = 0;
    int   gate_first = -1;
    int   gate_last  = -1;

    pulse_sequencer_v2_if sif ();

    pulse_sequencer_v2 #(.CLK_PER_US(CPU)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input logic [1:0] k, input int c, input int i, input int ty);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.idx  = i[4:0];
        e.typ  = ty[1:0];
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [1:0] k, input logic [4:0] i, input logic [1:0] ty);
        ev_t a;
        ev_t e;
        a.kind = k;
        a.cyc  = cyc;
        a.idx  = i;
        a.typ  = ty;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: actual kind=%0d cyc=%0d idx=%0d, required no event",
                     k, cyc, i);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL event: actual kind=%0d cyc=%0d idx=%0d typ=%0d, required kind=%0d cyc=%0d idx=%0d typ=%0d",
                         a.kind, a.cyc, a.idx, a.typ, e.kind, e.cyc, e.idx, e.typ);
            end
        end
    endtask

    // Monitor: compares every strobe against the scoreboard, tracks GATE.
    always @(negedge clk) begin
        if (!rst) begin
            if (sif.ERR)  pop_check(K_ERR, 5'd0, 2'd0);
            if (sif.DONE) pop_check(K_DONE, 5'd0, 2'd0);
            if (sif.IMP_START) begin
                pop_check(K_IMP, sif.IMP_INDEX, sif.TYPE_OUT);
                n_imp++;
                check("gate_at_imp_start", 64'(sif.GATE), 64'd1);
            end
            if (sif.GATE) begin
                gate_cnt++;
                if (gate_first < 0) gate_first = cyc;
                gate_last = cyc;
            end
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_params(input int timp, input int tper, input int num,
                              input int stag, input int ty);
        sif.T_IMPULSE   = timp[9:0];
        sif.T_PERIOD    = tper[12:0];
        sif.NUM_OF_IMP  = num[4:0];
        sif.STAGGER     = stag[7:0];
        sif.SIGNAL_TYPE = ty[1:0];
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({sif.GATE, sif.IMP_START, sif.IMP_INDEX, sif.TYPE_OUT,
                    sif.BUSY, sif.DONE, sif.ERR});
    endfunction

    initial begin
        int t;
        int n0;
        logic seen;

        sif.SIGN_START_GEN = 1'b0;
        set_params(0, 0, 0, 0, 0);
        rst = 1'b1;
        nclk(3);
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        nclk(2);

        // ---- Normal finite burst: 3 us on, 5 us period, 2 pulses ----------
        set_params(3, 5, 2, 0, 2);
        gate_cnt = 0; gate_first = -1; gate_last = -1;
        t = cyc;
        sif.SIGN_START_GEN = 1'b1;
        push_ev(K_IMP,  t + 1,  0, 2);
        push_ev(K_IMP,  t + 21, 1, 2);
        push_ev(K_DONE, t + 41, 0, 0);
        nclk(20);
        sif.SIGN_START_GEN = 1'b0;   // finite burst ignores the level
        nclk(25);
        check("burst_gate_cycles", 64'(gate_cnt),   64'd24);
        check("burst_gate_first",  64'(gate_first), 64'(t + 1));
        check("burst_gate_last",   64'(gate_last),  64'(t + 32));
        check("burst_busy_after",  64'(sif.BUSY),   64'd0);

        // ---- Invalid parameters -------------------------------------------
        set_params(10, 2, 1, 0, 1);
        gate_cnt = 0;
        t = cyc;
        sif.SIGN_START_GEN = 1'b1;
        push_ev(K_ERR, t + 1, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nclk(1);
            seen = seen | sif.BUSY | sif.GATE;
        end
        check("err_no_busy_gate", 64'(seen),     64'd0);
        check("err_no_gate_cnt",  64'(gate_cnt), 64'd0);
        sif.SIGN_START_GEN = 1'b0;
        nclk(2);

        // ---- Continuous mode, drop run-enable during pulse index 3 --------
        set_params(1, 2, 0, 0, 1);
        n0 = n_imp;
        t = cyc;
        sif.SIGN_START_GEN = 1'b1;
        push_ev(K_IMP,  t + 1,  0, 1);
        push_ev(K_IMP,  t + 9,  1, 1);
        push_ev(K_IMP,  t + 17, 2, 1);
        push_ev(K_IMP,  t + 25, 3, 1);
        push_ev(K_DONE, t + 33, 0, 0);
        nclk(26);
        check("cont_gate_in_pulse3", 64'(sif.GATE), 64'd1);
        sif.SIGN_START_GEN = 1'b0;
        nclk(12);
        check("cont_imp_start_count", 64'(n_imp - n0), 64'd4);
        check("cont_busy_after",      64'(sif.BUSY),   64'd0);

        // ---- Re-trigger mid-burst, then back-to-back start in DONE cycle --
        set_params(1, 2, 1, 0, 0);
        t = cyc;
        sif.SIGN_START_GEN = 1'b1;
        push_ev(K_IMP,  t + 1, 0, 0);
        push_ev(K_DONE, t + 9, 0, 0);
        nclk(2);
        sif.SIGN_START_GEN = 1'b0;
        nclk(1);
        sif.SIGN_START_GEN = 1'b1;   // ignored edge, parameter changes too
        set_params(4, 7, 5, 0, 3);
        nclk(2);
        sif.SIGN_START_GEN = 1'b0;
        nclk(4);
        check("b2b_done_cycle", 64'({sif.DONE, sif.BUSY}), 64'd2);
        set_params(2, 3, 2, 0, 3);
        sif.SIGN_START_GEN = 1'b1;
        push_ev(K_IMP,  t + 10, 0, 3);
        push_ev(K_IMP,  t + 22, 1, 3);
        push_ev(K_DONE, t + 34, 0, 0);
        nclk(2);
        sif.SIGN_START_GEN = 1'b0;
        nclk(30);

        // ---- Reset mid-pulse ----------------------------------------------
        set_params(3, 5, 3, 0, 2);
        t = cyc;
        sif.SIGN_START_GEN = 1'b1;
        push_ev(K_IMP, t + 1, 0, 2);
        nclk(4);
        check("rst_gate_before", 64'(sif.GATE), 64'd1);
        rst = 1'b1;
        sif.SIGN_START_GEN = 1'b0;
        nclk(1);
        check("rst_outputs_cleared", all_outs(), 64'd0);
        rst = 1'b0;
        nclk(40);
        check("rst_idle_after", 64'(sif.BUSY), 64'd0);

        // ---- Stagger: 5 us period, 2 us stagger, 3 pulses -----------------
        set_params(2, 5, 3, 2, 1);
        t = cyc;
        sif.SIGN_START_GEN = 1'b1;
        push_ev(K_IMP, t + 1,  0, 1);
        push_ev(K_IMP, t + 21, 1, 1);
`ifdef PULSE_SEQ_STAGGER_EN
        push_ev(K_IMP,  t + 49, 2, 1);
        push_ev(K_DONE, t + 69, 0, 0);
`else
        push_ev(K_IMP,  t + 41, 2, 1);
        push_ev(K_DONE, t + 61, 0, 0);
`endif
        nclk(2);
        sif.SIGN_START_GEN = 1'b0;
        nclk(75);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
